// File: rtl/dmem_bus_if.sv
// Bundles the CPU-side and bus-side signals of the data-memory bridge.
// The master modport is the bridge's view; slave is the view of the CPU/memory environment.
interface dmem_bus_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_fault;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              bus_err;

  modport master (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
    input  bus_ack, bus_rdata, bus_err,
    output cpu_rdata, cpu_stall, cpu_fault,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
    output bus_ack, bus_rdata, bus_err,
    input  cpu_rdata, cpu_stall, cpu_fault,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Mem-stage to word bus bridge: alignment check, lane steering, load extension,
// and bounded wait for the bus acknowledge.
module dmem_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  dmem_bus_if.master io_mem
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_fault;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_mis;
  logic              w_accept;
  logic              w_in_req;
  logic              w_stall;
  logic              w_fault;
  logic [31:0]       w_rdata;

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_replicate(input logic [31:0] d, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // CPU-facing responses: stall/fault react to the request in the same cycle.
  always_comb begin
    w_mis    = f_misaligned(io_mem.cpu_size, io_mem.cpu_addr[1:0]);
    w_accept = (r_state == S_IDLE) && io_mem.cpu_req_valid && !w_mis;
    w_in_req = (r_state == S_REQ);
    w_stall  = 1'b0;
    w_fault  = 1'b0;
    w_rdata  = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        w_stall = io_mem.cpu_req_valid && !w_mis;
        w_fault = io_mem.cpu_req_valid && w_mis;
      end
      S_REQ: begin
        w_stall = 1'b1;
      end
      S_RESP: begin
        w_fault = r_fault;
        w_rdata = (!r_we && !r_fault) ? f_load_ext(r_rdata, r_size, r_addr[1:0], r_unsigned)
                                      : 32'h0000_0000;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  assign io_mem.cpu_stall = w_stall;
  assign io_mem.cpu_fault = w_fault;
  assign io_mem.cpu_rdata = w_rdata;

  // Bus side is driven purely from latched state so it cannot glitch while waiting.
  assign io_mem.bus_req   = w_in_req;
  assign io_mem.bus_we    = w_in_req && r_we;
  assign io_mem.bus_be    = w_in_req ? f_be(r_size, r_addr[1:0]) : 4'b0000;
  assign io_mem.bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign io_mem.bus_wdata = f_replicate(r_wdata, r_size);

  // State machine, request latches, wait counter and fault flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0000_0000;
      r_rdata    <= 32'h0000_0000;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= io_mem.cpu_we;
            r_addr     <= io_mem.cpu_addr;
            r_size     <= io_mem.cpu_size;
            r_unsigned <= io_mem.cpu_unsigned;
            r_wdata    <= io_mem.cpu_wdata;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // Error wins over a simultaneous ack.
          if (io_mem.bus_err) begin
            r_fault <= 1'b1;
            r_state <= S_RESP;
          end else if (io_mem.bus_ack) begin
            r_rdata <= io_mem.bus_rdata;
            r_fault <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge built with a 4-cycle bus timeout.
module tb_dmem_bus_bridge;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   st;

  dmem_bus_if #(.ADDR_W(32)) u_if ();

  dmem_bus_bridge #(.TIMEOUT(4), .ADDR_W(32)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_mem (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.cpu_req_valid = 1'b0;
    u_if.cpu_we        = 1'b0;
    u_if.cpu_addr      = 32'h0000_0000;
    u_if.cpu_wdata     = 32'h0000_0000;
    u_if.cpu_size      = 2'b00;
    u_if.cpu_unsigned  = 1'b0;
    u_if.bus_ack       = 1'b0;
    u_if.bus_rdata     = 32'h0000_0000;
    u_if.bus_err       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rst_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.bus_we !== 1'b0) begin n_err++; $display("FAIL rst_bus_we got=%b exp=0", u_if.bus_we); end
    n_vec++; if (u_if.bus_be !== 4'b0000) begin n_err++; $display("FAIL rst_bus_be got=%b exp=0000", u_if.bus_be); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", u_if.cpu_stall); end
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got=%b exp=0", u_if.cpu_fault); end
    n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", u_if.cpu_rdata); end
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_load_byte();
    st = 0;
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_addr = 32'h0000_1003;
    u_if.cpu_size = 2'b00; u_if.cpu_unsigned = 1'b0;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL lb_accept_bus_req got=%b exp=0", u_if.bus_req); end
    cyc();
    u_if.cpu_req_valid = 1'b0;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (u_if.bus_req !== 1'b1) begin n_err++; $display("FAIL lb_bus_req got=%b exp=1", u_if.bus_req); end
    n_vec++; if (u_if.bus_addr !== 32'h0000_1000) begin n_err++; $display("FAIL lb_bus_addr got=%h exp=00001000", u_if.bus_addr); end
    n_vec++; if (u_if.bus_be !== 4'b1000) begin n_err++; $display("FAIL lb_bus_be got=%b exp=1000", u_if.bus_be); end
    n_vec++; if (u_if.bus_we !== 1'b0) begin n_err++; $display("FAIL lb_bus_we got=%b exp=0", u_if.bus_we); end
    cyc();
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    cyc();
    u_if.bus_ack = 1'b1; u_if.bus_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    cyc();
    u_if.bus_ack = 1'b0; u_if.bus_rdata = 32'h0000_0000;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (u_if.cpu_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_resp_rdata got=%h exp=ffffff80", u_if.cpu_rdata); end
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL lb_resp_fault got=%b exp=0", u_if.cpu_fault); end
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL lb_resp_bus_req got=%b exp=0", u_if.bus_req); end
    cyc();
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (st !== 4) begin n_err++; $display("FAIL lb_stall_cycles got=%0d exp=4", st); end
    n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL lb_idle_rdata got=%h exp=0", u_if.cpu_rdata); end
  endtask

  task automatic test_store_half();
    st = 0;
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b1; u_if.cpu_addr = 32'h0000_2002;
    u_if.cpu_size = 2'b01; u_if.cpu_unsigned = 1'b0; u_if.cpu_wdata = 32'h0000_BEEF;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    cyc();
    u_if.cpu_req_valid = 1'b0; u_if.cpu_wdata = 32'h0000_0000; u_if.bus_ack = 1'b1;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (u_if.bus_we !== 1'b1) begin n_err++; $display("FAIL sh_bus_we got=%b exp=1", u_if.bus_we); end
    n_vec++; if (u_if.bus_be !== 4'b1100) begin n_err++; $display("FAIL sh_bus_be got=%b exp=1100", u_if.bus_be); end
    n_vec++; if (u_if.bus_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_bus_wdata got=%h exp=beefbeef", u_if.bus_wdata); end
    n_vec++; if (u_if.bus_addr !== 32'h0000_2000) begin n_err++; $display("FAIL sh_bus_addr got=%h exp=00002000", u_if.bus_addr); end
    cyc();
    u_if.bus_ack = 1'b0;
    @(negedge clk);
    if (u_if.cpu_stall === 1'b1) st++;
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL sh_resp_fault got=%b exp=0", u_if.cpu_fault); end
    n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL sh_resp_rdata got=%h exp=0", u_if.cpu_rdata); end
    n_vec++; if (st !== 2) begin n_err++; $display("FAIL sh_stall_cycles got=%0d exp=2", st); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h0000_3001, 32'h0000_3011, 32'h0000_3000, 32'h0000_3002};
    for (int i = 0; i < 4; i++) begin
      cyc();
      u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_size = sz[i]; u_if.cpu_addr = ad[i];
      @(negedge clk);
      n_vec++; if (u_if.cpu_fault !== 1'b1) begin n_err++; $display("FAIL mis%0d_fault got=%b exp=1", i, u_if.cpu_fault); end
      n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall got=%b exp=0", i, u_if.cpu_stall); end
      n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL mis%0d_rdata got=%h exp=0", i, u_if.cpu_rdata); end
      n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL mis%0d_bus_req got=%b exp=0", i, u_if.bus_req); end
    end
    cyc();
    u_if.cpu_req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL mis_after_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL mis_after_fault got=%b exp=0", u_if.cpu_fault); end
  endtask

  task automatic test_err_ack();
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_size = 2'b10; u_if.cpu_addr = 32'h0000_4000;
    cyc();
    u_if.cpu_req_valid = 1'b0; u_if.bus_ack = 1'b1; u_if.bus_err = 1'b1; u_if.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b1) begin n_err++; $display("FAIL ea_bus_req got=%b exp=1", u_if.bus_req); end
    cyc();
    u_if.bus_ack = 1'b0; u_if.bus_err = 1'b0; u_if.bus_rdata = 32'h0000_0000;
    @(negedge clk);
    n_vec++; if (u_if.cpu_fault !== 1'b1) begin n_err++; $display("FAIL ea_resp_fault got=%b exp=1", u_if.cpu_fault); end
    n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL ea_resp_rdata got=%h exp=0", u_if.cpu_rdata); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL ea_resp_stall got=%b exp=0", u_if.cpu_stall); end
    cyc();
    @(negedge clk);
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL ea_idle_fault got=%b exp=0", u_if.cpu_fault); end
  endtask

  task automatic test_timeout();
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_size = 2'b10; u_if.cpu_addr = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      u_if.cpu_req_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (u_if.bus_req !== 1'b1) begin n_err++; $display("FAIL to_req%0d_bus_req got=%b exp=1", i, u_if.bus_req); end
    end
    cyc();
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL to_resp_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.cpu_fault !== 1'b1) begin n_err++; $display("FAIL to_resp_fault got=%b exp=1", u_if.cpu_fault); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL to_resp_stall got=%b exp=0", u_if.cpu_stall); end
    cyc();
    @(negedge clk);
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL to_idle_fault got=%b exp=0", u_if.cpu_fault); end
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL to_idle_bus_req got=%b exp=0", u_if.bus_req); end
  endtask

  task automatic test_reset_in_req();
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_size = 2'b10; u_if.cpu_addr = 32'h0000_6000;
    cyc();
    u_if.cpu_req_valid = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b1) begin n_err++; $display("FAIL rr_req2_bus_req got=%b exp=1", u_if.bus_req); end
    cyc();
    reset = 1'b1; u_if.bus_ack = 1'b1; u_if.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rr_after_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rr_after_stall got=%b exp=0", u_if.cpu_stall); end
    cyc();
    u_if.bus_ack = 1'b0; u_if.bus_rdata = 32'h0000_0000;
    @(negedge clk);
    n_vec++; if (u_if.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rr_ack_ignored_rdata got=%h exp=0", u_if.cpu_rdata); end
    n_vec++; if (u_if.cpu_fault !== 1'b0) begin n_err++; $display("FAIL rr_ack_ignored_fault got=%b exp=0", u_if.cpu_fault); end
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rr_ack_ignored_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rr_ack_ignored_stall got=%b exp=0", u_if.cpu_stall); end
  endtask

  task automatic test_back_to_back();
    cyc();
    u_if.cpu_req_valid = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_size = 2'b01;
    u_if.cpu_unsigned = 1'b1; u_if.cpu_addr = 32'h0000_7002;
    cyc();
    u_if.bus_ack = 1'b1; u_if.bus_rdata = 32'h8001_0000;
    @(negedge clk);
    n_vec++; if (u_if.bus_be !== 4'b1100) begin n_err++; $display("FAIL bb_first_be got=%b exp=1100", u_if.bus_be); end
    cyc();
    u_if.bus_ack = 1'b0; u_if.bus_rdata = 32'h0000_0000;
    @(negedge clk);
    n_vec++; if (u_if.cpu_rdata !== 32'h0000_8001) begin n_err++; $display("FAIL bb_first_rdata got=%h exp=00008001", u_if.cpu_rdata); end
    n_vec++; if (u_if.cpu_stall !== 1'b0) begin n_err++; $display("FAIL bb_resp_stall got=%b exp=0", u_if.cpu_stall); end
    cyc();
    u_if.cpu_addr = 32'h0000_7000; u_if.cpu_unsigned = 1'b0;
    @(negedge clk);
    n_vec++; if (u_if.bus_req !== 1'b0) begin n_err++; $display("FAIL bb_idle_bus_req got=%b exp=0", u_if.bus_req); end
    n_vec++; if (u_if.cpu_stall !== 1'b1) begin n_err++; $display("FAIL bb_idle_accept_stall got=%b exp=1", u_if.cpu_stall); end
    cyc();
    u_if.cpu_req_valid = 1'b0; u_if.bus_ack = 1'b1; u_if.bus_rdata = 32'h0000_8001;
    @(negedge clk);
    n_vec++; if (u_if.bus_be !== 4'b0011) begin n_err++; $display("FAIL bb_second_be got=%b exp=0011", u_if.bus_be); end
    cyc();
    u_if.bus_ack = 1'b0; u_if.bus_rdata = 32'h0000_0000;
    @(negedge clk);
    n_vec++; if (u_if.cpu_rdata !== 32'hFFFF_8001) begin n_err++; $display("FAIL bb_second_rdata got=%h exp=ffff8001", u_if.cpu_rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load_byte();
    idle_inputs();
    test_store_half();
    idle_inputs();
    test_misaligned();
    idle_inputs();
    test_err_ack();
    idle_inputs();
    test_timeout();
    idle_inputs();
    test_reset_in_req();
    idle_inputs();
    test_back_to_back();
    idle_inputs();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
